forwarding_hazard_unit: RTL and testbench

FORWARDING_HAZARD_UNIT -- requirements
Module: forwarding_hazard_unit

---
 rtl/forwarding_hazard_unit.sv | 100 ++++++++++
 tb/tb_forwarding_hazard_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_hazard_unit.sv
// Operand-bypass selection and load-use stall detection for a 5-stage pipeline.
// Shadows the EX/MEM/WB occupants and counts stall cycles with saturation.
module forwarding_hazard_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_dest,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        flush,
  output logic [1:0]  upper_ALU_mux_select_line,
  output logic [1:0]  lower_ALU_mux_select_line,
  output logic        stall,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic [4:0] dest;
    logic       reg_write;
    logic       mem_read;
  } entry_t;

  localparam entry_t     BUBBLE  = '0;
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  entry_t      r_ex, r_mem, r_wb;
  entry_t      w_id_entry;
  logic        w_stall;
  logic        w_load_use;
  logic [15:0] r_stall_count;
  logic        w_unused;

  // A load in MEM has no data yet, so MEM is skipped and WB gets its chance.
  function automatic logic [1:0] fwd_sel(input logic       uses,
                                         input logic [4:0] src,
                                         input entry_t     ex,
                                         input entry_t     mem,
                                         input entry_t     wb);
    if (ex.valid && uses && mem.valid && mem.reg_write && !mem.mem_read &&
        mem.dest != 5'd0 && mem.dest == src)
      return SEL_MEM;
    if (ex.valid && uses && wb.valid && wb.reg_write &&
        wb.dest != 5'd0 && wb.dest == src)
      return SEL_WB;
    return SEL_RF;
  endfunction

  assign w_id_entry = '{valid:     1'b1,
                        rs:        id_rs,
                        rt:        id_rt,
                        uses_rs:   id_uses_rs,
                        uses_rt:   id_uses_rt,
                        dest:      id_dest,
                        reg_write: id_reg_write,
                        mem_read:  id_mem_read};

  assign w_load_use = (id_uses_rs && id_rs == r_ex.dest) ||
                      (id_uses_rt && id_rt == r_ex.dest);

  // Flush outranks the hazard: a squashed instruction never needs its operands.
  assign w_stall = id_valid && !flush && r_ex.valid && r_ex.mem_read &&
                   r_ex.reg_write && r_ex.dest != 5'd0 && w_load_use;

  assign upper_ALU_mux_select_line = fwd_sel(r_ex.uses_rs, r_ex.rs, r_ex, r_mem, r_wb);
  assign lower_ALU_mux_select_line = fwd_sel(r_ex.uses_rt, r_ex.rt, r_ex, r_mem, r_wb);
  assign stall                     = w_stall;
  assign stall_count               = r_stall_count;

  // Operand fields of the older stages are only tracked, never compared.
  assign w_unused = ^{r_mem.rs, r_mem.rt, r_mem.uses_rs, r_mem.uses_rt,
                      r_wb.rs, r_wb.rt, r_wb.uses_rs, r_wb.uses_rt, r_wb.mem_read};

  // NOTE: non-blocking assignments so every stage shifts from its pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex          <= BUBBLE;
      r_mem         <= BUBBLE;
      r_wb          <= BUBBLE;
      r_stall_count <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= (id_valid && !w_stall && !flush) ? w_id_entry : BUBBLE;
      if (w_stall && r_stall_count != 16'hFFFF)
        r_stall_count <= r_stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed checks of bypass selects, load-use stall, flush, reset and counter
// saturation for forwarding_hazard_unit.
module tb_forwarding_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_reg_write, id_mem_read, id_uses_rs, id_uses_rt;
  logic        flush;
  logic [1:0]  upper_sel, lower_sel;
  logic        stall;
  logic [15:0] stall_count;

  int errors = 0;
  int checks = 0;

  forwarding_hazard_unit dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .id_valid                  (id_valid),
    .id_rs                     (id_rs),
    .id_rt                     (id_rt),
    .id_dest                   (id_dest),
    .id_reg_write              (id_reg_write),
    .id_mem_read               (id_mem_read),
    .id_uses_rs                (id_uses_rs),
    .id_uses_rt                (id_uses_rt),
    .flush                     (flush),
    .upper_ALU_mux_select_line (upper_sel),
    .lower_ALU_mux_select_line (lower_sel),
    .stall                     (stall),
    .stall_count               (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, away from sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dest, input logic rw, input logic mr,
                       input logic urs, input logic urt, input logic fl);
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_dest      = dest;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_uses_rs   = urs;
    id_uses_rt   = urt;
    flush        = fl;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    nop();
    #12;
    check("reset_stall", stall, 1'b0);
    check("reset_upper", upper_sel, 2'b00);
    check("reset_lower", lower_sel, 2'b00);
    check("reset_count", stall_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU chain: add r3,r1,r2 ; sub r4,r3,r5
    drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 1, 1, 0);
    check("alu_add_stall", stall, 1'b0);
    tick();
    drive(1, 5'd3, 5'd5, 5'd4, 1, 0, 1, 1, 0);
    check("alu_sub_stall", stall, 1'b0);
    tick();
    nop();
    check("alu_upper", upper_sel, 2'b01);
    check("alu_lower", lower_sel, 2'b00);
    check("alu_no_stall", stall, 1'b0);
    drain();

    // Distance-2: add r3 ; or r8,r9,r10 ; consumer reads r3 as rt
    drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 1, 1, 0);
    tick();
    drive(1, 5'd9, 5'd10, 5'd8, 1, 0, 1, 1, 0);
    tick();
    drive(1, 5'd11, 5'd3, 5'd12, 1, 0, 1, 1, 0);
    tick();
    nop();
    check("dist2_lower", lower_sel, 2'b10);
    check("dist2_upper", upper_sel, 2'b00);
    drain();

    // Load-use: lw r6 ; add r7,r6,r6
    drive(1, 5'd1, 5'd0, 5'd6, 1, 1, 1, 0, 0);
    check("lu_lw_stall", stall, 1'b0);
    tick();
    drive(1, 5'd6, 5'd6, 5'd7, 1, 0, 1, 1, 0);
    check("lu_stall", stall, 1'b1);
    check("lu_count0", stall_count, 16'd0);
    tick();
    check("lu_stall_once", stall, 1'b0);
    check("lu_count1", stall_count, 16'd1);
    check("lu_bubble_upper", upper_sel, 2'b00);
    tick();
    nop();
    check("lu_upper", upper_sel, 2'b10);
    check("lu_lower", lower_sel, 2'b10);
    drain();

    // r0 producer (ALU and load) never forwards or stalls
    drive(1, 5'd1, 5'd2, 5'd0, 1, 0, 1, 1, 0);
    tick();
    drive(1, 5'd0, 5'd0, 5'd9, 1, 0, 1, 1, 0);
    check("r0_alu_stall", stall, 1'b0);
    tick();
    nop();
    check("r0_upper", upper_sel, 2'b00);
    check("r0_lower", lower_sel, 2'b00);
    drain();
    drive(1, 5'd1, 5'd0, 5'd0, 1, 1, 1, 0, 0);
    tick();
    drive(1, 5'd0, 5'd0, 5'd9, 1, 0, 1, 1, 0);
    check("r0_load_stall", stall, 1'b0);
    drain();

    // MEM priority: add r3 ; add r3 ; consumer rs=r3
    drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 1, 1, 0);
    tick();
    drive(1, 5'd4, 5'd5, 5'd3, 1, 0, 1, 1, 0);
    tick();
    drive(1, 5'd3, 5'd9, 5'd10, 1, 0, 1, 1, 0);
    tick();
    nop();
    check("prio_upper", upper_sel, 2'b01);
    check("prio_lower", lower_sel, 2'b00);
    drain();

    // Flush against a load-use hazard
    drive(1, 5'd1, 5'd0, 5'd6, 1, 1, 1, 0, 0);
    tick();
    drive(1, 5'd6, 5'd6, 5'd7, 1, 0, 1, 1, 1);
    check("flush_stall", stall, 1'b0);
    tick();
    nop();
    check("flush_count", stall_count, 16'd1);
    drain();

    // Flushed consumer must not reach EX
    drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 1, 1, 0);
    tick();
    drive(1, 5'd3, 5'd3, 5'd4, 1, 0, 1, 1, 1);
    tick();
    nop();
    check("flush_bubble_upper", upper_sel, 2'b00);
    check("flush_bubble_lower", lower_sel, 2'b00);
    drain();

    // Reset in the middle of a stall
    drive(1, 5'd1, 5'd0, 5'd6, 1, 1, 1, 0, 0);
    tick();
    drive(1, 5'd6, 5'd6, 5'd7, 1, 0, 1, 1, 0);
    check("rst_pre_stall", stall, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_upper", upper_sel, 2'b00);
    check("rst_lower", lower_sel, 2'b00);
    check("rst_count", stall_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_release_stall", stall, 1'b0);
    tick();
    check("rst_no_resume", stall, 1'b0);
    // The held add r7 entered EX on the first edge; a reader of r7 gets MEM
    drive(1, 5'd7, 5'd0, 5'd8, 1, 0, 1, 0, 0);
    tick();
    nop();
    check("rst_first_edge_loads", upper_sel, 2'b01);
    drain();

    // Saturation: lw r6,0(r6) repeated stalls every other cycle
    check("sat_start", stall_count, 16'd0);
    drive(1, 5'd6, 5'd0, 5'd6, 1, 1, 1, 0, 0);
    repeat (20) tick();
    check("sat_count10", stall_count, 16'd10);
    repeat (2 * 65534 - 20) tick();
    check("sat_fffe", stall_count, 16'hFFFE);
    repeat (2) tick();
    check("sat_ffff", stall_count, 16'hFFFF);
    repeat (2 * 5) tick();
    check("sat_hold", stall_count, 16'hFFFF);
    nop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
